// File: rtl/cmd_dispatch.sv
// Command sequencer: decodes opcode/data words into flight setpoints, runs calibration,
// returns an ACK/NACK byte and enforces a link-loss watchdog.
module cmd_dispatch #(
    parameter int         TMO_W = 26,
    parameter logic [7:0] ACK   = 8'hA5,
    parameter logic [7:0] NACK  = 8'hEE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    output logic               clr_cmd_rdy,
    output logic [7:0]         resp,
    output logic               send_resp,
    input  logic               resp_sent,
    input  logic               cal_done,
    output logic               strt_cal,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               motors_off,
    output logic               tmo
);
    typedef enum logic [1:0] {IDLE, CAL, SEND, WAIT_TX} state_t;

    localparam logic [7:0] OP_PTCH = 8'h02;
    localparam logic [7:0] OP_ROLL = 8'h03;
    localparam logic [7:0] OP_YAW  = 8'h04;
    localparam logic [7:0] OP_THR  = 8'h05;
    localparam logic [7:0] OP_CAL  = 8'h06;
    localparam logic [7:0] OP_EMER = 8'h07;
    localparam logic [7:0] OP_MOFF = 8'h08;

    state_t                state_q, state_d;
    logic [TMO_W-1:0]      wdog_q, wdog_d;
    logic signed [15:0]    d_ptch_q, d_ptch_d, d_roll_q, d_roll_d, d_yaw_q, d_yaw_d;
    logic [8:0]            thrst_q, thrst_d;
    logic                  motors_off_q, motors_off_d;
    logic [7:0]            resp_q, resp_d;
    logic                  send_resp_q, send_resp_d;
    logic                  strt_cal_q, strt_cal_d;
    logic                  tmo_q, tmo_d;
    logic                  resp_sent_q, resp_sent_d;

    // Held low during reset so a pending command is not reported consumed until release.
    assign clr_cmd_rdy = rst_n && (state_q == IDLE) && cmd_rdy;

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        d_ptch_d     = d_ptch_q;
        d_roll_d     = d_roll_q;
        d_yaw_d      = d_yaw_q;
        thrst_d      = thrst_q;
        motors_off_d = motors_off_q;
        resp_d       = resp_q;
        send_resp_d  = 1'b0;
        strt_cal_d   = 1'b0;
        tmo_d        = 1'b0;
        resp_sent_d  = resp_sent;
        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    wdog_d       = '0;
                    motors_off_d = 1'b0;
                    resp_d       = ACK;
                    state_d      = SEND;
                    send_resp_d  = 1'b1;
                    case (cmd)
                        OP_PTCH: d_ptch_d = data;
                        OP_ROLL: d_roll_d = data;
                        OP_YAW:  d_yaw_d  = data;
                        OP_THR:  thrst_d  = data[8:0];
                        OP_CAL: begin
                            state_d     = CAL;
                            send_resp_d = 1'b0;
                            strt_cal_d  = 1'b1;
                        end
                        OP_EMER: begin
                            d_ptch_d = '0;
                            d_roll_d = '0;
                            d_yaw_d  = '0;
                            thrst_d  = '0;
                        end
                        OP_MOFF: begin
                            motors_off_d = 1'b1;
                            thrst_d      = '0;
                        end
                        default: resp_d = NACK;
                    endcase
                end else if (wdog_q == '1) begin
                    wdog_d   = '0;
                    tmo_d    = 1'b1;
                    d_ptch_d = '0;
                    d_roll_d = '0;
                    d_yaw_d  = '0;
                    thrst_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            // strt_cal_q marks the first CAL cycle, where a leftover cal_done is ignored.
            CAL: begin
                if (!strt_cal_q && cal_done) begin
                    resp_d      = ACK;
                    state_d     = SEND;
                    send_resp_d = 1'b1;
                end
            end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (resp_sent && !resp_sent_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wdog_q       <= '0;
            d_ptch_q     <= '0;
            d_roll_q     <= '0;
            d_yaw_q      <= '0;
            thrst_q      <= '0;
            motors_off_q <= 1'b1;
            resp_q       <= '0;
            send_resp_q  <= 1'b0;
            strt_cal_q   <= 1'b0;
            tmo_q        <= 1'b0;
            resp_sent_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            d_ptch_q     <= d_ptch_d;
            d_roll_q     <= d_roll_d;
            d_yaw_q      <= d_yaw_d;
            thrst_q      <= thrst_d;
            motors_off_q <= motors_off_d;
            resp_q       <= resp_d;
            send_resp_q  <= send_resp_d;
            strt_cal_q   <= strt_cal_d;
            tmo_q        <= tmo_d;
            resp_sent_q  <= resp_sent_d;
        end
    end

    assign d_ptch     = d_ptch_q;
    assign d_roll     = d_roll_q;
    assign d_yaw      = d_yaw_q;
    assign thrst      = thrst_q;
    assign motors_off = motors_off_q;
    assign resp       = resp_q;
    assign send_resp  = send_resp_q;
    assign strt_cal   = strt_cal_q;
    assign tmo        = tmo_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Randomized self-checking bench for cmd_dispatch with a setpoint-register model
// and a small watchdog (TMO_W=4) so the timeout is reachable.
module tb_cmd_dispatch;
    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_rdy = 1'b0, resp_sent = 1'b0, cal_done = 1'b0;
    logic [7:0] cmd = '0;
    logic [15:0] data = '0;
    logic clr_cmd_rdy, send_resp, strt_cal, motors_off, tmo;
    logic [7:0] resp;
    logic signed [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0] thrst;

    int total = 0, bad = 0;

    // Behavioural model of the register file the commands write
    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thr;
    logic        m_moff;
    logic [7:0]  m_resp;

    // Observations captured by run_cmd
    logic o_clr, o_send, o_tmo, o_rchg;
    logic [7:0] o_resp;
    int o_xsend;
    logic [15:0] o_ptch, o_roll, o_yaw;
    logic [8:0] o_thr;
    logic o_moff;

    cmd_dispatch #(.TMO_W(4), .ACK(ACK), .NACK(NACK)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .resp_sent(resp_sent), .cal_done(cal_done), .strt_cal(strt_cal),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst),
        .motors_off(motors_off), .tmo(tmo)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptch = '0; m_roll = '0; m_yaw = '0; m_thr = '0; m_moff = 1'b1; m_resp = '0;
    endtask

    task automatic model_apply(input logic [7:0] op, input logic [15:0] dat);
        m_resp = (op >= 8'h02 && op <= 8'h08) ? ACK : NACK;
        m_moff = (op == 8'h08);
        if (op == 8'h02) m_ptch = dat;
        if (op == 8'h03) m_roll = dat;
        if (op == 8'h04) m_yaw  = dat;
        if (op == 8'h05) m_thr  = dat[8:0];
        if (op == 8'h07) begin m_ptch = '0; m_roll = '0; m_yaw = '0; m_thr = '0; end
        if (op == 8'h08) m_thr = '0;
    endtask

    task automatic do_reset();
        cmd_rdy = 1'b0; resp_sent = 1'b0; cal_done = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    // Drives one non-calibrate command from an IDLE negedge; returns at the IDLE negedge after the ack.
    task automatic run_cmd(input logic [7:0] op, input logic [15:0] dat, input int txd);
        cmd_rdy = 1'b1; cmd = op; data = dat;
        #1 o_clr = clr_cmd_rdy;
        o_tmo = 1'b0; o_xsend = 0; o_rchg = 1'b0;
        @(negedge clk); cmd_rdy = 1'b0;
        o_send = send_resp; o_resp = resp; o_tmo = tmo;
        o_ptch = d_ptch; o_roll = d_roll; o_yaw = d_yaw; o_thr = thrst; o_moff = motors_off;
        repeat (txd) begin
            @(negedge clk);
            if (send_resp) o_xsend++;
            if (resp !== o_resp) o_rchg = 1'b1;
            if (tmo) o_tmo = 1'b1;
        end
        resp_sent = 1'b1;
        @(negedge clk); resp_sent = 1'b0;
        if (resp !== o_resp) o_rchg = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if ({d_ptch, d_roll, d_yaw, thrst} !== '0) begin bad++;
            $display("FAIL reset_setpoints: got %h want 0", {d_ptch, d_roll, d_yaw, thrst}); end
        total++; if (motors_off !== 1'b1) begin bad++;
            $display("FAIL reset_motors_off: got %b want 1", motors_off); end
        total++; if (resp !== 8'h00) begin bad++;
            $display("FAIL reset_resp: got %h want 00", resp); end
        total++; if ({send_resp, strt_cal, tmo, clr_cmd_rdy} !== 4'b0) begin bad++;
            $display("FAIL reset_pulses: got %b want 0000", {send_resp, strt_cal, tmo, clr_cmd_rdy}); end
    endtask

    task automatic test_thrust();
        do_reset();
        run_cmd(8'h05, 16'h0123, 3);
        total++; if (o_clr !== 1'b1) begin bad++; $display("FAIL thr_clr: got %b want 1", o_clr); end
        total++; if (o_thr !== 9'h123 || o_moff !== 1'b0) begin bad++;
            $display("FAIL thr_value: got thrst=%h moff=%b want 123/0", o_thr, o_moff); end
        total++; if (o_send !== 1'b1 || o_resp !== ACK) begin bad++;
            $display("FAIL thr_send: got send=%b resp=%h want 1/a5", o_send, o_resp); end
        total++; if (o_xsend !== 0 || o_rchg !== 1'b0) begin bad++;
            $display("FAIL thr_waittx: got xsend=%0d rchg=%b want 0/0", o_xsend, o_rchg); end
        // Accepted immediately after the resp_sent edge means it is back in IDLE
        run_cmd(8'h03, 16'h0042, 1);
        total++; if (o_clr !== 1'b1 || o_roll !== 16'h0042) begin bad++;
            $display("FAIL thr_idle_return: got clr=%b roll=%h want 1/0042", o_clr, o_roll); end
    endtask

    task automatic test_back_to_back();
        int sends = 0, early = 0;
        do_reset();
        cmd_rdy = 1'b1; cmd = 8'h02; data = 16'hFF38;
        #1 total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_clr1: got %b want 1", clr_cmd_rdy); end
        @(negedge clk); cmd = 8'h04; data = 16'h0064;
        if (send_resp) sends++;
        total++; if (d_ptch !== 16'hFF38 || resp !== ACK) begin bad++;
            $display("FAIL b2b_ptch: got ptch=%h resp=%h want ff38/a5", d_ptch, resp); end
        #1 if (clr_cmd_rdy) early++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 if (clr_cmd_rdy) early++;
            if (send_resp) sends++;
        end
        resp_sent = 1'b1;
        @(negedge clk); #1;
        total++; if (early !== 0 || clr_cmd_rdy !== 1'b1) begin bad++;
            $display("FAIL b2b_hold: got early=%0d clr=%b want 0/1", early, clr_cmd_rdy); end
        @(negedge clk); cmd_rdy = 1'b0;
        if (send_resp) sends++;
        total++; if (d_yaw !== 16'sd100 || d_ptch !== 16'hFF38) begin bad++;
            $display("FAIL b2b_yaw: got yaw=%h ptch=%h want 0064/ff38", d_yaw, d_ptch); end
        // resp_sent still high from the first byte: a third command must wait for a fresh edge
        early = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h1111;
            if (send_resp) sends++;
            if (i == 2) resp_sent = 1'b0;
            #1 if (clr_cmd_rdy) early++;
        end
        @(negedge clk); resp_sent = 1'b1; #1 if (clr_cmd_rdy) early++;
        total++; if (sends !== 2) begin bad++; $display("FAIL b2b_ack_count: got %0d want 2", sends); end
        @(negedge clk); #1;
        total++; if (early !== 0 || clr_cmd_rdy !== 1'b1) begin bad++;
            $display("FAIL b2b_stale: got early=%0d clr=%b want 0/1", early, clr_cmd_rdy); end
        @(negedge clk); cmd_rdy = 1'b0; resp_sent = 1'b0;
        total++; if (d_roll !== 16'h1111 || send_resp !== 1'b1) begin bad++;
            $display("FAIL b2b_third: got roll=%h send=%b want 1111/1", d_roll, send_resp); end
        @(negedge clk); resp_sent = 1'b1;
        @(negedge clk); resp_sent = 1'b0;
    endtask

    task automatic test_nack();
        logic [7:0] op;
        do_reset();
        run_cmd(8'h02, 16'h1234, 1); model_apply(8'h02, 16'h1234);
        run_cmd(8'h05, 16'h00AB, 1); model_apply(8'h05, 16'h00AB);
        for (int k = 0; k < 3; k++) begin
            op = (k == 0) ? 8'h3C : 8'(($urandom_range(9, 255)));
            run_cmd(op, 16'($urandom), $urandom_range(1, 4));
            model_apply(op, 16'h0);
            total++; if (o_resp !== NACK || o_send !== 1'b1) begin bad++;
                $display("FAIL nack_resp op=%h: got resp=%h send=%b want ee/1", op, o_resp, o_send); end
            total++; if ({o_ptch, o_roll, o_yaw, o_thr} !== {m_ptch, m_roll, m_yaw, m_thr}) begin bad++;
                $display("FAIL nack_regs op=%h: got %h want %h", op, {o_ptch, o_roll, o_yaw, o_thr},
                         {m_ptch, m_roll, m_yaw, m_thr}); end
        end
    endtask

    task automatic test_cal();
        int pulses = 0, early = 0, sends = 0;
        do_reset();
        cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0;
        #1 total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL cal_clr: got %b want 1", clr_cmd_rdy); end
        @(negedge clk); cmd_rdy = 1'b0;
        cal_done = 1'b1;  // leftover level in the first CAL cycle must be ignored
        total++; if (strt_cal !== 1'b1) begin bad++; $display("FAIL cal_strt: got %b want 1", strt_cal); end
        for (int c = 2; c <= 51; c++) begin
            @(negedge clk);
            cal_done = (c == 51);
            if (c == 10) begin cmd_rdy = 1'b1; cmd = 8'h04; data = 16'h7A5C; end
            if (strt_cal) pulses++;
            if (send_resp) sends++;
            #1 if (clr_cmd_rdy) early++;
        end
        @(negedge clk); cal_done = 1'b0;
        total++; if (pulses !== 0 || early !== 0 || sends !== 0) begin bad++;
            $display("FAIL cal_wait: got pulses=%0d early=%0d sends=%0d want 0/0/0", pulses, early, sends); end
        total++; if (send_resp !== 1'b1 || resp !== ACK) begin bad++;
            $display("FAIL cal_send: got send=%b resp=%h want 1/a5", send_resp, resp); end
        @(negedge clk); resp_sent = 1'b1;
        @(negedge clk); resp_sent = 1'b0;
        #1 total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL cal_pending: got %b want 1", clr_cmd_rdy); end
        @(negedge clk); cmd_rdy = 1'b0;
        total++; if (d_yaw !== 16'h7A5C || send_resp !== 1'b1) begin bad++;
            $display("FAIL cal_after: got yaw=%h send=%b want 7a5c/1", d_yaw, send_resp); end
        @(negedge clk); resp_sent = 1'b1;
        @(negedge clk); resp_sent = 1'b0;
    endtask

    task automatic test_watchdog();
        int seen = 0;
        do_reset();
        run_cmd(8'h02, 16'h0F0F, 1);
        run_cmd(8'h05, 16'd100, 2);
        // Counter is 0 in this cycle; 15 is reached 15 idle cycles later, pulse the cycle after
        for (int i = 0; i < 16; i++) begin if (tmo) seen++; @(negedge clk); end
        total++; if (seen !== 0 || tmo !== 1'b1) begin bad++;
            $display("FAIL wd_pulse: got early=%0d tmo=%b want 0/1", seen, tmo); end
        total++; if ({d_ptch, d_roll, d_yaw, thrst} !== '0 || motors_off !== 1'b0) begin bad++;
            $display("FAIL wd_zero: got %h moff=%b want 0/0", {d_ptch, d_roll, d_yaw, thrst}, motors_off); end
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (tmo) seen++; end
        @(negedge clk);
        total++; if (seen !== 0 || tmo !== 1'b1) begin bad++;
            $display("FAIL wd_wrap: got early=%0d tmo=%b want 0/1", seen, tmo); end
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (tmo) seen++; end
        cmd_rdy = 1'b1; cmd = 8'h02; data = 16'h0055;
        #1 total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL wd_cmd_clr: got %b want 1", clr_cmd_rdy); end
        @(negedge clk); cmd_rdy = 1'b0;
        total++; if (seen !== 0 || tmo !== 1'b0 || send_resp !== 1'b1) begin bad++;
            $display("FAIL wd_cmd_wins: got early=%0d tmo=%b send=%b want 0/0/1", seen, tmo, send_resp); end
        @(negedge clk); resp_sent = 1'b1;
        @(negedge clk); resp_sent = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_cmd(8'h05, 16'h0050, 1);
        cmd_rdy = 1'b1; cmd = 8'h08; data = 16'h0;
        @(negedge clk); cmd_rdy = 1'b0;
        total++; if (motors_off !== 1'b1 || thrst !== 9'h0) begin bad++;
            $display("FAIL moff_cmd: got moff=%b thrst=%h want 1/0", motors_off, thrst); end
        @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h2222;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({d_ptch, d_roll, d_yaw, thrst, resp} !== '0 || motors_off !== 1'b1 ||
                     {send_resp, strt_cal, tmo, clr_cmd_rdy} !== 4'b0) begin bad++;
            $display("FAIL mid_reset: got regs=%h moff=%b pulses=%b want 0/1/0000",
                     {d_ptch, d_roll, d_yaw, thrst, resp}, motors_off, {send_resp, strt_cal, tmo, clr_cmd_rdy}); end
        @(negedge clk); rst_n = 1'b1; model_reset();
        #1 total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", clr_cmd_rdy); end
        @(negedge clk); cmd_rdy = 1'b0;
        total++; if (d_roll !== 16'h2222 || send_resp !== 1'b1 || motors_off !== 1'b0) begin bad++;
            $display("FAIL mid_after: got roll=%h send=%b moff=%b want 2222/1/0", d_roll, send_resp, motors_off); end
        @(negedge clk); resp_sent = 1'b1;
        @(negedge clk); resp_sent = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ops [6] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08};
        logic [7:0] op;
        logic [15:0] dat;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 7);
            op = (r < 6) ? ops[r] : 8'($urandom_range(9, 255));
            dat = 16'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_cmd(op, dat, $urandom_range(1, 6));
            model_apply(op, dat);
            total++; if (o_clr !== 1'b1 || o_send !== 1'b1 || o_resp !== m_resp) begin bad++;
                $display("FAIL rnd_hs n=%0d op=%h: got clr=%b send=%b resp=%h want 1/1/%h",
                         n, op, o_clr, o_send, o_resp, m_resp); end
            total++; if ({o_ptch, o_roll, o_yaw, o_thr, o_moff} !== {m_ptch, m_roll, m_yaw, m_thr, m_moff}) begin bad++;
                $display("FAIL rnd_regs n=%0d op=%h: got %h want %h", n, op,
                         {o_ptch, o_roll, o_yaw, o_thr, o_moff}, {m_ptch, m_roll, m_yaw, m_thr, m_moff}); end
            total++; if (o_xsend !== 0 || o_rchg !== 1'b0 || o_tmo !== 1'b0) begin bad++;
                $display("FAIL rnd_tx n=%0d: got xsend=%0d rchg=%b tmo=%b want 0/0/0", n, o_xsend, o_rchg, o_tmo); end
        end
    endtask

    initial begin
        test_reset();
        test_thrust();
        test_back_to_back();
        test_nack();
        test_cal();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmd_dispatch.md
# cmd_dispatch

Command sequencer sitting between the BLE-facing serial command receiver and the flight controller. It consumes each 24-bit command (8-bit opcode, 16-bit data) flagged by `cmd_rdy`, updates the flight setpoint registers, and runs calibration. It returns a one-byte positive/negative acknowledge through the serial transmitter and enforces a link-loss watchdog that forces an emergency landing.

## Interface
- `TMO_W`, 26, width of the watchdog counter; timeout fires at count 2^TMO_W − 1.
- `ACK`, 8'hA5, response byte for a successfully executed command.
- `NACK`, 8'hEE, response byte for an unknown opcode.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_rdy`  in  1  level, a complete command is held on `cmd`/`data`.
- `cmd`  in  8  opcode.
- `data`  in  16  parameter.
- `clr_cmd_rdy`  out  1  one-cycle pulse, command consumed.
- `resp`  out  8  response byte, held stable from `send_resp` until completion.
- `send_resp`  out  1  one-cycle pulse, start transmission of `resp`.
- `resp_sent`  in  1  transmitter done, level.
- `cal_done`  in  1  calibration finished, level or pulse.
- `strt_cal`  out  1  one-cycle pulse, start calibration.
- `d_ptch`, `d_roll`, `d_yaw`  out  16 each  signed angle setpoints.
- `thrst`  out  9  thrust setpoint.
- `motors_off`  out  1  motors disabled.
- `tmo`  out  1  one-cycle pulse, watchdog expired.

## Operation
- Opcodes:
  - 0x02: `d_ptch`←`data`.
  - 0x03: `d_roll`←`data`.
  - 0x04: `d_yaw`←`data`.
  - 0x05: `thrst`←`data[8:0]`.
  - 0x06 CALIBRATE.
  - 0x07 EMER_LAND: `d_ptch`/`d_roll`/`d_yaw`/`thrst`←0.
  - 0x08 MTRS_OFF: `motors_off`←1, `thrst`←0.
  - Any other opcode: no register change, `resp`=`NACK`.
- All commands except MTRS_OFF clear `motors_off`.
- States:
  - IDLE: on `cmd_rdy`, `clr_cmd_rdy`=1 (combinational, same cycle), decode, load setpoints and `resp` at that edge. Next state is CAL if the opcode is 0x06, else SEND.
  - CAL: `strt_cal`=1 in the first CAL cycle only. Wait for `cal_done`=1 (sampled from the second CAL cycle onward), then `resp`←`ACK` and go to SEND.
  - SEND: `send_resp`=1 for this single cycle, then go to WAIT_TX.
  - WAIT_TX: wait for a rising edge of `resp_sent` (high now, low the previous cycle), then go to IDLE. A stale high `resp_sent` from the prior byte is ignored.
- Commands arriving outside IDLE are not consumed. `cmd_rdy` stays high and the command is executed on return to IDLE, in order.
- Watchdog:
  - The counter increments only in IDLE with `cmd_rdy`=0.
  - It clears when a command is accepted.
  - At terminal count: `d_ptch`/`d_roll`/`d_yaw`/`thrst`←0 and `tmo`=1 for one cycle; `motors_off` is unchanged. The counter wraps to 0 and keeps running.
  - No response byte is sent on timeout.
- `cmd_rdy`=1 in the same cycle as terminal count: the command wins, the counter clears, and no `tmo` pulse is issued.

## Timing
- Reset values:
  - State IDLE, watchdog 0.
  - `d_ptch`/`d_roll`/`d_yaw`=0, `thrst`=0, `motors_off`=1.
  - `resp`=0.
  - `send_resp`/`strt_cal`/`clr_cmd_rdy`/`tmo`=0.
- Reset mid-operation returns all state to these values immediately. Any pending `cmd_rdy` is processed after release.
- Non-calibrate command, `cmd_rdy` first seen high in cycle 0:
  - Cycle 0: `clr_cmd_rdy`=1.
  - Cycle 1: setpoint visible and `send_resp`=1.
  - Cycle 2 onward: WAIT_TX.
  - The next command can be accepted no earlier than the cycle after the `resp_sent` rising edge.
- CALIBRATE:
  - Cycle 1: `strt_cal` pulse.
  - `cal_done` seen in cycle n: SEND in cycle n+1.
- `resp` changes only at command accept or at calibration completion, never during WAIT_TX.
- All outputs except `clr_cmd_rdy` are registered.

## Test plan
- Reset, then 0x05/0x0123 → `clr_cmd_rdy` pulse in cycle 0; `thrst`=9'h123, `motors_off`=0 and `send_resp` with `resp`=A5 in cycle 1. `resp_sent` rising edge → IDLE.
- 0x02/0xFF38 then 0x04/0x0064 back-to-back, with the second `cmd_rdy` held during WAIT_TX → `d_ptch`=16'hFF38 first. The second command is consumed only after the first `resp_sent` edge; `d_yaw`=100; exactly two A5 bytes are sent.
- Opcode 0x3C → `resp`=EE; no setpoint changes.
- 0x06 with `cal_done` asserted 50 cycles after `strt_cal` → single `strt_cal` pulse; `send_resp` exactly one cycle after `cal_done`; `resp`=A5. Verify a `cmd_rdy` issued during CAL waits.
- `TMO_W`=4, thrst=100, no commands → `tmo` pulse after 15 idle cycles; all setpoints 0. Repeat with `cmd_rdy` at count 15 → no `tmo`.
- 0x08 then async reset asserted in WAIT_TX → all outputs return to reset values; `motors_off`=1.
